spi_slave: RTL and testbench

SPI slave peripheral on the CPU memory bus; the far-end partner of spi_master, consuming SCK/MOSI/SS and producing MISO.
- Oversamples the SPI pins in the clk_cpu domain, shifts full-duplex frames, double-buffers TX, holds one RX word.
- Raises interrpt on receive or overrun.
- Used as on-chip loopback target for spi_master bring-up and as the slave port on SoC variants.

---
 rtl/spi_slave_if.sv | 19 +
 rtl/spi_slave.sv | 131 +++++++++++++
 tb/tb_spi_slave.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: CPU memory-bus port of spi_slave.
// The CPU side uses the master modport; the peripheral uses slave.
interface spi_slave_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_valid;
    logic        cpu_instr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (
        output cpu_addr, cpu_wdata, cpu_wstrb, cpu_valid, cpu_instr,
        input  mem_ready, mem_rdata
    );
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wstrb, cpu_valid, cpu_instr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: memory-mapped SPI slave, pins oversampled in clk_cpu, double-buffered TX, one RX word.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release MISO when deselected or idle.
module spi_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h30,
    parameter int          DATA_W    = 16
) (
    input  logic       clk_cpu,
    input  logic       rst,
    spi_slave_if.slave bus,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic       SS,
    output logic       interrpt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [4:0] ctrl;
    logic [DATA_W-1:0] tx_buf, tx_sh, rx_sh, rx_data;
    logic tx_full, rx_full, overrun, underrun, frame_err;
    logic cpol_l, cpha_l, lsb_l;
    logic [5:0] bit_cnt;
    logic [2:0] sck_s, ss_s;
    logic [1:0] mosi_s;
    logic hit, wr, rd;
    logic [1:0] reg_sel;
    logic [31:0] rd_val, wmask;
    logic start, abort, lead, trail, sample, shift, last, miso_bit;

    assign hit = bus.cpu_valid & ~bus.cpu_instr & (bus.cpu_addr >= BASE_ADDR) & (bus.cpu_addr <= BASE_ADDR + 32'd3);
    assign wr = hit & |bus.cpu_wstrb;
    assign rd = hit & ~|bus.cpu_wstrb;
    assign reg_sel = 2'(bus.cpu_addr - BASE_ADDR);
    assign wmask = {{8{bus.cpu_wstrb[3]}}, {8{bus.cpu_wstrb[2]}}, {8{bus.cpu_wstrb[1]}}, {8{bus.cpu_wstrb[0]}}};
    assign rd_val = reg_sel == 2'd0 ? 32'(ctrl) :
                    reg_sel == 2'd1 ? 32'(tx_buf) :
                    reg_sel == 2'd2 ? 32'(rx_data) :
                    32'({frame_err, underrun, overrun, tx_full, rx_full, state != IDLE});

    // Edges are judged against the CPOL captured at frame start, not the live CTRL bit
    assign lead = (sck_s[1] != sck_s[2]) & (sck_s[2] == cpol_l);
    assign trail = (sck_s[1] != sck_s[2]) & (sck_s[1] == cpol_l);
    assign sample = (state == SHIFT) & (cpha_l ? trail : lead);
    assign shift = (state == SHIFT) & (cpha_l ? lead & (bit_cnt != 6'd0) : trail);
    assign last = bit_cnt == 6'(DATA_W - 1);
    assign start = (state == IDLE) & ctrl[0] & ss_s[2] & ~ss_s[1];
    assign abort = (state == SHIFT) & (~ctrl[0] | (~ss_s[2] & ss_s[1]));
    assign miso_bit = lsb_l ? tx_sh[0] : tx_sh[DATA_W-1];

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = (ss_s[1] | state == IDLE) ? 1'bz : (state == SHIFT) & miso_bit;
`else
    assign MISO = (state == SHIFT) & miso_bit;
`endif

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (start ? SHIFT : IDLE) :
                   state == SHIFT ? (abort ? IDLE : (sample & last) ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            sck_s <= '0;
            ss_s <= '0;
            mosi_s <= '0;
            ctrl <= '0;
            tx_buf <= '0;
            tx_sh <= '0;
            rx_sh <= '0;
            rx_data <= '0;
            tx_full <= 1'b0;
            rx_full <= 1'b0;
            overrun <= 1'b0;
            underrun <= 1'b0;
            frame_err <= 1'b0;
            cpol_l <= 1'b0;
            cpha_l <= 1'b0;
            lsb_l <= 1'b0;
            bit_cnt <= '0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            interrpt <= 1'b0;
        end else begin
            sck_s <= {sck_s[1:0], SCK};
            ss_s <= {ss_s[1:0], SS};
            mosi_s <= {mosi_s[0], MOSI};
            bus.mem_ready <= hit;
            bus.mem_rdata <= hit ? rd_val : 32'd0;
            interrpt <= ctrl[4] & (rx_full | overrun);
            if (wr & reg_sel == 2'd3 & bus.cpu_wstrb[0]) begin
                overrun <= overrun & ~bus.cpu_wdata[3];
                underrun <= underrun & ~bus.cpu_wdata[4];
                frame_err <= frame_err & ~bus.cpu_wdata[5];
            end
            if (wr & reg_sel == 2'd0) ctrl <= 5'((32'(ctrl) & ~wmask) | (bus.cpu_wdata & wmask));
            if (start) begin
                cpol_l <= ctrl[1];
                cpha_l <= ctrl[2];
                lsb_l <= ctrl[3];
                bit_cnt <= '0;
                tx_sh <= tx_full ? tx_buf : '0;
                tx_full <= 1'b0;
                if (!tx_full) underrun <= 1'b1;
            end
            // A write landing in the load cycle refills the buffer after the old word is taken
            if (wr & reg_sel == 2'd1) begin
                tx_buf <= DATA_W'((32'(tx_buf) & ~wmask) | (bus.cpu_wdata & wmask));
                tx_full <= 1'b1;
            end
            if (sample) begin
                rx_sh <= lsb_l ? {mosi_s[1], rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], mosi_s[1]};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (shift) tx_sh <= lsb_l ? tx_sh >> 1 : tx_sh << 1;
            if (abort & ctrl[0]) frame_err <= 1'b1;
            if (rd & reg_sel == 2'd2) rx_full <= 1'b0;
            if (state == DONE) begin
                if (!rx_full | (rd & reg_sel == 2'd2)) begin
                    rx_data <= rx_sh;
                    rx_full <= 1'b1;
                end else overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed plus randomized frames against a register/frame-level model of spi_slave.
module tb_spi_slave;
    localparam logic [31:0] BASE = 32'h30;
    logic clk_cpu = 1'b0;
    logic rst = 1'b1;
    logic SCK = 1'b0;
    logic MOSI = 1'b0;
    logic SS = 1'b1;
    logic MISO, interrpt;
    int n_asserts = 0;
    int n_fail = 0;
    logic [4:0] m_ctrl;
    logic [15:0] m_tx, m_rx;
    logic m_txf, m_rxf, m_ovr, m_und, m_ferr;

    spi_slave_if bus();
    spi_slave #(.BASE_ADDR(BASE), .DATA_W(16)) dut (
        .clk_cpu(clk_cpu), .rst(rst), .bus(bus),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SS(SS), .interrpt(interrpt)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {26'd0, m_ferr, m_und, m_ovr, m_txf, m_rxf, 1'b0};
    endfunction

    function automatic logic m_irq();
        return m_ctrl[4] & (m_rxf | m_ovr);
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_tx = '0; m_rx = '0;
        m_txf = 0; m_rxf = 0; m_ovr = 0; m_und = 0; m_ferr = 0;
    endtask

    task automatic bus_rw(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb,
                          input logic instr, output logic rdy, output logic [31:0] rdata);
        @(negedge clk_cpu);
        bus.cpu_addr = addr; bus.cpu_wdata = d; bus.cpu_wstrb = strb;
        bus.cpu_instr = instr; bus.cpu_valid = 1'b1;
        @(negedge clk_cpu);
        bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0;
        rdy = bus.mem_ready; rdata = bus.mem_rdata;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] strb);
        logic r;
        logic [31:0] x, m;
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        bus_rw(BASE + 32'(off), d, strb, 1'b0, r, x);
        check("wr_ready", 32'(r), 32'd1);
        if (off == 2'd0) m_ctrl = 5'((32'(m_ctrl) & ~m) | (d & m));
        if (off == 2'd1) begin
            m_tx = 16'((32'(m_tx) & ~m) | (d & m));
            m_txf = 1;
        end
        if (off == 2'd3 && strb[0]) begin
            m_ovr &= ~d[3]; m_und &= ~d[4]; m_ferr &= ~d[5];
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        logic r;
        logic [31:0] d;
        bus_rw(BASE + 32'(off), 32'd0, 4'd0, 1'b0, r, d);
        check({tag, "_ready"}, 32'(r), 32'd1);
        check(tag, d, exp);
        if (off == 2'd2) m_rxf = 0;
    endtask

    // Plain SPI master: each SCK phase lasts 'half' clk_cpu cycles; MISO captured at the master's sample edge
    task automatic spi_frame(input logic [15:0] mo, input logic cpol, input logic cpha, input logic lsb,
                             input int half, output logic [15:0] mi);
        int b;
        mi = '0;
        SCK = cpol;
        repeat (4) @(negedge clk_cpu);
        SS = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = lsb ? i : 15 - i;
            if (!cpha) MOSI = mo[b];
            repeat (half) @(negedge clk_cpu);
            if (!cpha) mi[b] = MISO;
            SCK = ~cpol;
            if (cpha) MOSI = mo[b];
            repeat (half) @(negedge clk_cpu);
            if (cpha) mi[b] = MISO;
            SCK = cpol;
        end
        repeat (half) @(negedge clk_cpu);
        SS = 1'b1;
        repeat (6) @(negedge clk_cpu);
    endtask

    task automatic run_frame(input logic [15:0] mo, input int half);
        logic [15:0] mi, exp_mi;
        spi_frame(mo, m_ctrl[1], m_ctrl[2], m_ctrl[3], half, mi);
        exp_mi = m_txf ? m_tx : 16'h0;
        if (!m_txf) m_und = 1;
        m_txf = 0;
        if (!m_rxf) begin
            m_rx = mo; m_rxf = 1;
        end else m_ovr = 1;
        check("miso_word", 32'(mi), 32'(exp_mi));
        rd_chk("status_after_frame", 2'd3, m_status());
        check("irq_after_frame", 32'(interrpt), 32'(m_irq()));
    endtask

    initial begin
        logic r;
        logic [31:0] d;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
        bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_cpu);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_irq", 32'(interrpt), 32'd0);
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b0;
        rd_chk("rst_status", 2'd3, 32'd0);
        rd_chk("rst_ctrl", 2'd0, 32'd0);
        rd_chk("rst_tx", 2'd1, 32'd0);

        bus_rw(BASE + 32'd1, 32'd0, 4'd0, 1'b1, r, d);
        check("instr_no_ready", 32'(r), 32'd0);
        bus_rw(BASE + 32'd4, 32'd0, 4'd0, 1'b0, r, d);
        check("miss_no_ready", 32'(r), 32'd0);
        check("idle_rdata", bus.mem_rdata, 32'd0);

        // Mode 0 loopback
        wr(2'd0, 32'h11, 4'hf);
        wr(2'd1, 32'hA5C3, 4'hf);
        rd_chk("tx_read", 2'd1, 32'hA5C3);
        rd_chk("status_txfull", 2'd3, m_status());
        run_frame(16'h8003, 5);
        check("mode0_irq", 32'(interrpt), 32'd1);
        rd_chk("mode0_rx", 2'd2, 32'h8003);
        repeat (2) @(negedge clk_cpu);
        check("irq_cleared", 32'(interrpt), 32'd0);

        wr(2'd1, 32'hA5C3, 4'hf);
        wr(2'd1, 32'hFF, 4'b0001);
        rd_chk("tx_bytestrobe", 2'd1, 32'hA5FF);

        // Mode 3 back-to-back without reading: second frame overruns and underruns
        wr(2'd0, 32'h07, 4'hf);
        run_frame(16'h1234, 4);
        run_frame(16'h5678, 4);
        rd_chk("mode3_status", 2'd3, m_status());
        rd_chk("mode3_rx", 2'd2, 32'h1234);
        wr(2'd3, 32'h08, 4'hf);
        rd_chk("ovr_w1c", 2'd3, m_status());
        wr(2'd3, 32'h10, 4'hf);
        rd_chk("und_w1c", 2'd3, m_status());

        for (int k = 0; k < 8; k++) begin
            logic [2:0] cfg;
            cfg = 3'($urandom_range(0, 7));
            wr(2'd0, 32'({1'b1, cfg, 1'b1}), 4'hf);
            if ($urandom_range(0, 1) == 1) wr(2'd1, $urandom & 32'hFFFF, 4'hf);
            run_frame(16'($urandom), int'($urandom_range(3, 6)));
            if ($urandom_range(0, 1) == 1) rd_chk("rand_rx", 2'd2, 32'(m_rx));
            wr(2'd3, 32'h38, 4'hf);
        end

        // Abort after 7 SCK edges
        if (m_rxf) rd_chk("pre_abort_rx", 2'd2, 32'(m_rx));
        wr(2'd0, 32'h11, 4'hf);
        wr(2'd1, 32'h3C3C, 4'hf);
        SCK = 1'b0;
        repeat (4) @(negedge clk_cpu);
        SS = 1'b0;
        repeat (5) @(negedge clk_cpu);
        for (int i = 0; i < 7; i++) begin
            MOSI = 1'($urandom);
            SCK = ~SCK;
            repeat (5) @(negedge clk_cpu);
        end
        SS = 1'b1;
        repeat (6) @(negedge clk_cpu);
        SCK = 1'b0;
        repeat (4) @(negedge clk_cpu);
        m_txf = 0; m_ferr = 1;
        rd_chk("abort_status", 2'd3, m_status());
        wr(2'd3, 32'h20, 4'hf);
        wr(2'd1, 32'h0F0F, 4'hf);
        run_frame(16'hBEEF, 5);
        rd_chk("post_abort_rx", 2'd2, 32'hBEEF);
        run_frame(16'h4242, 3);
        check("pre_rst_irq", 32'(interrpt), 32'd1);

        // Reset mid-frame: outputs must drop without a clock edge
        wr(2'd1, 32'hFFFF, 4'hf);
        SCK = 1'b0;
        repeat (4) @(negedge clk_cpu);
        SS = 1'b0;
        repeat (6) @(negedge clk_cpu);
        check("midframe_miso", 32'(MISO), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_miso", 32'(MISO), 32'd0);
        check("async_rst_irq", 32'(interrpt), 32'd0);
        check("async_rst_rdata", bus.mem_rdata, 32'd0);
        @(negedge clk_cpu);
        rst = 1'b0;
        SS = 1'b1;
        model_reset();
        repeat (4) @(negedge clk_cpu);
        rd_chk("post_rst_status", 2'd3, 32'd0);
        rd_chk("post_rst_ctrl", 2'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
